// File: rtl/pdm_transmitter.sv
// PDM transmitter: a 16-bit sample FIFO feeds a first-order error-feedback modulator.
// The modulator emits one bit per generated PDM clock period.
module pdm_transmitter #(
  parameter int CLK_DIV    = 32,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            enable_in,
  input  logic [15:0]                     sample_in,
  input  logic                            sample_valid_in,
  output logic                            sample_ready_out,
  output logic                            pdm_clk_out,
  output logic                            pdm_data_out,
  output logic                            pdm_tick_out,
  output logic                            underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_next;
  logic          running;
  logic          tick_next;
  logic [SW-1:0] smp_cnt;
  logic          boundary;
  logic [15:0]   cur_sample;
  logic [16:0]   acc;
  logic [16:0]   sum;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          push;
  logic          pop;

  assign sample_ready_out = (count < NW'(FIFO_DEPTH)) && !rst_in;
  assign fifo_count_out   = count;

  // The first enabled cycle after idle restarts the divider at 0 so it ticks at once.
  always_comb begin
    div_next  = '0;
    if (running && (div_cnt != CW'(CLK_DIV - 1))) begin
      div_next = div_cnt + CW'(1);
    end else begin
      div_next = '0;
    end
    tick_next = enable_in && (div_next == '0);
    boundary  = tick_next && (smp_cnt == SW'(OSR - 1));
    pop       = boundary && (count != '0);
    push      = sample_valid_in && sample_ready_out;
    sum       = acc + {1'b0, ~cur_sample[15], cur_sample[14:0]};
  end

  // PDM clock divider and tick generation
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      running      <= 1'b0;
      pdm_clk_out  <= 1'b0;
      pdm_tick_out <= 1'b0;
    end else if (enable_in) begin
      div_cnt      <= div_next;
      running      <= 1'b1;
      pdm_clk_out  <= (div_next < CW'(CLK_DIV / 2));
      pdm_tick_out <= tick_next;
    end else begin
      div_cnt      <= '0;
      running      <= 1'b0;
      pdm_clk_out  <= 1'b0;
      pdm_tick_out <= 1'b0;
    end
  end

  // Modulator, sample counter and current-sample reload at sample boundaries
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc          <= '0;
      smp_cnt      <= '0;
      cur_sample   <= '0;
      pdm_data_out <= 1'b0;
      underrun_out <= 1'b0;
    end else if (tick_next) begin
      pdm_data_out <= sum[16];
      acc          <= {1'b0, sum[15:0]};
      smp_cnt      <= boundary ? '0 : smp_cnt + SW'(1);
      underrun_out <= boundary && (count == '0);
      if (pop) begin
        cur_sample <= mem[rd_ptr];
      end else begin
        cur_sample <= cur_sample;
      end
    end else begin
      underrun_out <= 1'b0;
      if (!enable_in) begin
        pdm_data_out <= 1'b0;
      end else begin
        pdm_data_out <= pdm_data_out;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

endmodule

// File: tb/tb_pdm_transmitter.sv
// Self-checking bench for pdm_transmitter: a cycle model built from bit-period
// arithmetic and a sample queue, table-driven density checks, and corner sequences.
module tb_pdm_transmitter;
  localparam int CLK_DIV = 32;
  localparam int OSR     = 64;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        ready, pclk, pdata, ptick, under;
  logic [2:0]  count;

  pdm_transmitter #(.CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .sample_in(sample),
    .sample_valid_in(valid), .sample_ready_out(ready), .pdm_clk_out(pclk),
    .pdm_data_out(pdata), .pdm_tick_out(ptick), .underrun_out(under),
    .fifo_count_out(count));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state: bit position inside the period, bits within the sample
  bit m_run;
  int m_phase, m_bits, m_cur, m_acc;
  int q[$];
  bit e_clk, e_tick, e_data, e_under, m_popped;

  typedef struct { logic [15:0] x; int ones; } dens_t;
  dens_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_bits = 0; m_cur = 0; m_acc = 0;
    q.delete();
    e_clk = 0; e_tick = 0; e_data = 0; e_under = 0; m_popped = 0;
  endtask

  task automatic step();
    bit take;
    int s;
    take = valid && (q.size() < DEPTH);
    @(posedge clk);
    m_popped = 0;
    e_under = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (enable) begin
        e_tick = !m_run || (m_phase == CLK_DIV - 1);
        m_phase = e_tick ? 0 : m_phase + 1;
        m_run = 1;
        e_clk = (m_phase < CLK_DIV / 2);
        if (e_tick) begin
          s = m_acc + m_cur + 32768;
          e_data = (s >= 65536);
          m_acc = s % 65536;
          m_bits++;
          if (m_bits == OSR) begin
            m_bits = 0;
            if (q.size() > 0) begin
              m_cur = q.pop_front();
              m_popped = 1;
            end else begin
              e_under = 1;
            end
          end
        end
      end else begin
        m_run = 0; m_phase = 0; e_clk = 0; e_tick = 0; e_data = 0;
      end
      if (take) q.push_back(int'($signed(sample)));
    end
    #1;
    chk("tick", ptick, e_tick);
    chk("pdm_clk", pclk, e_clk);
    chk("pdm_data", pdata, e_data);
    chk("underrun", under, e_under);
    chk("fifo_count", count, q.size());
    chk("ready", ready, (!rst && q.size() < DEPTH));
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 6000) begin step(); n++; end
    chk("drained", count, 0);
  endtask

  initial begin
    int hi, uc, n, ones, ticks;
    logic [7:0] seq;
    logic [15:0] vals[5];

    tbl[0] = '{16'h8000, 0};    // x=-32768: all zeros
    tbl[1] = '{16'h0000, 32};   // x=0: half density
    tbl[2] = '{16'hC000, 16};   // x=-16384
    tbl[3] = '{16'h4000, 48};   // x=16384
    tbl[4] = '{16'h7C00, 63};   // u=64512
    tbl[5] = '{16'h8400, 1};    // u=1024
    vals = '{16'h1234, 16'h8000, 16'h7FFF, 16'h0000, 16'hABCD};

    model_reset();
    #3;
    chk("rst_clk", pclk, 0);
    chk("rst_data", pdata, 0);
    chk("rst_tick", ptick, 0);
    chk("rst_under", under, 0);
    chk("rst_ready", ready, 0);
    chk("rst_count", count, 0);
    step(); step();

    // idle stream after reset: x=0 pattern, 16-cycle-high clock, one underrun per 64 ticks
    rst = 0; enable = 1;
    hi = 0; uc = 0; seq = 8'h00; n = 0;
    for (int i = 0; i < OSR * CLK_DIV; i++) begin
      step();
      if (i < CLK_DIV) hi += pclk;
      uc += under;
      if (ptick && n < 8) begin seq = {seq[6:0], pdata}; n++; end
    end
    chk("clk_high_cycles", hi, CLK_DIV / 2);
    chk("underruns_per_sample", uc, 1);
    chk("first_bits", seq, 8'b01010101);

    // density per sample period for values whose 64*u is a multiple of 65536
    foreach (tbl[k]) begin
      wait_empty();
      sample = tbl[k].x; valid = 1; step(); valid = 0;
      n = 0;
      while (!m_popped && n < 6000) begin step(); n++; end
      chk("popped", count, 0);
      ones = 0; ticks = 0; n = 0;
      while (ticks < OSR && n < 4000) begin
        step(); n++;
        if (ptick) begin ticks++; ones += pdata; end
      end
      chk($sformatf("density_%04h", tbl[k].x), ones, tbl[k].ones);
    end

    // five back-to-back offers just after a boundary: four accepted
    wait_empty();
    n = 0;
    while (!e_under && n < 6000) begin step(); n++; end
    chk("underrun_seen", under, 1);
    for (int k = 0; k < 5; k++) begin
      sample = vals[k]; valid = 1;
      if (k == 4) chk("ready_5th", ready, 0);
      step();
    end
    valid = 0;
    chk("full_count", count, 4);

    // push offered in the boundary-pop cycle of a full FIFO
    n = 0;
    while (!(m_run && m_phase == CLK_DIV - 1 && m_bits == OSR - 1) && n < 6000) begin step(); n++; end
    chk("still_full", count, 4);
    sample = 16'h0F0F; valid = 1;
    chk("ready_full", ready, 0);
    step();
    chk("count_after_pop", count, 3);
    step();
    chk("count_after_push", count, 4);
    valid = 0;

    // enable gap mid-sample
    repeat (700) step();
    enable = 0;
    hi = 0;
    repeat (100) begin step(); hi += pclk + pdata; end
    chk("gap_low", hi, 0);
    enable = 1;
    step();
    chk("reenable_tick", ptick, 1);
    repeat (3000) step();

    // asynchronous reset mid-run with samples queued
    rst = 1;
    #2;
    chk("arst_clk", pclk, 0);
    chk("arst_data", pdata, 0);
    chk("arst_ready", ready, 0);
    chk("arst_count", count, 0);
    step(); step();
    rst = 0;
    repeat (200) step();

    // randomized traffic
    for (int i = 0; i < 12000; i++) begin
      enable = ($urandom_range(0, 39) != 0);
      valid = ($urandom_range(0, 199) == 0);
      sample = 16'($urandom);
      step();
    end
    valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdm_transmitter.md
PDM_TRANSMITTER -- requirements
Module: pdm_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 32: clk_in cycles per PDM bit period; even, >=4.
REQ-002 Parameter OSR, default 64: PDM bits per audio sample.
REQ-003 Parameter FIFO_DEPTH, default 4: sample FIFO entries; power of 2.
REQ-004 clk_in  input  1: single system clock (98.3 MHz); all logic on rising edge.
REQ-005 rst_in  input  1: asynchronous, active-high reset.
REQ-006 enable_in  input  1: runs the PDM clock and modulator when high.
REQ-007 sample_in  input  16: signed two's-complement audio sample.
REQ-008 sample_valid_in  input  1: sample_in valid this cycle.
REQ-009 sample_ready_out  output  1: FIFO can accept a sample this cycle.
REQ-010 pdm_clk_out  output  1: generated PDM bit clock.
REQ-011 pdm_data_out  output  1: PDM bitstream.
REQ-012 pdm_tick_out  output  1: one-cycle pulse marking each new PDM bit.
REQ-013 underrun_out  output  1: one-cycle pulse when a sample boundary finds the FIFO empty.
REQ-014 fifo_count_out  output  clog2(FIFO_DEPTH)+1: FIFO occupancy.

Function
REQ-015 The divider counter SHALL count 0..CLK_DIV-1 and wrap while enable_in=1; it SHALL hold at 0 while enable_in=0.
REQ-016 pdm_clk_out SHALL be registered: high while the divider count < CLK_DIV/2 and enable_in=1, else low.
REQ-017 pdm_tick_out SHALL pulse for exactly one cycle, in the same cycle pdm_clk_out rises (count transitions to 0 with enable_in=1).
REQ-018 pdm_data_out SHALL update only on tick cycles, so it is stable across the pdm_clk_out falling edge where the receiver samples.
REQ-019 Handshake: a push occurs when sample_valid_in=1 and sample_ready_out=1.
REQ-020 sample_ready_out SHALL equal (fifo_count_out < FIFO_DEPTH) and not rst_in; it does not depend on a same-cycle pop.
REQ-021 The FIFO SHALL be first-in-first-out with wrap-around pointers. A simultaneous push and pop leaves the count unchanged.
REQ-022 A sample counter SHALL increment on each tick and wrap at OSR-1; the tick at count OSR-1 is a sample boundary.
REQ-023 At a sample boundary with the FIFO non-empty, the head entry SHALL be popped into the current-sample register, taking effect from the next tick.
REQ-024 At a sample boundary with the FIFO empty, the current sample SHALL be held (zero-order hold) and underrun_out SHALL pulse for that cycle.
REQ-025 Modulator: first-order error feedback using a 17-bit accumulator acc.
REQ-026 On each tick, u = current sample + 32768 (unsigned 16-bit offset) and sum = acc + u.
REQ-027 On each tick, pdm_data_out <= (sum >= 65536) and acc <= sum mod 65536.
REQ-028 The long-run ones density SHALL be (x+32768)/65536. x=-32768 gives constant 0.
REQ-029 With enable_in=0: pdm_data_out SHALL be 0; acc, the sample counter and the current sample SHALL hold; the FIFO SHALL still accept pushes.
REQ-030 When enable_in rises, the first tick SHALL occur in the cycle enable_in is first sampled high.

Reset
REQ-031 While rst_in=1, asynchronously: divider, sample counter, acc, current sample, FIFO pointers and count = 0.
REQ-032 While rst_in=1: pdm_clk_out=0, pdm_data_out=0, pdm_tick_out=0, underrun_out=0, sample_ready_out=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued samples; the first cycle after release behaves as power-up.

Verification
REQ-034 Reset release, enable_in=1, no pushes -> pdm_clk_out period 32 cycles, 16 high; pdm_data_out sequence 0,1,0,1...; underrun_out pulses every 64 ticks.
REQ-035 Push 0x7FFF once, then hold -> after the next boundary, 65535 ones per 65536 bits; no pushes after reset otherwise give x=0 pattern.
REQ-036 Push 0x8000 -> pdm_data_out constant 0 from the tick after the boundary.
REQ-037 Push 5 samples back-to-back with valid held -> 4 accepted, sample_ready_out low on 5th; fifo_count_out=4; pops at boundaries in push order.
REQ-038 Full FIFO, push offered in a boundary-pop cycle -> push not accepted that cycle, accepted the next cycle; count 4->3->4.
REQ-039 enable_in=0 for 100 cycles mid-sample, then 1 -> clk/data low during the gap; acc and sample counter resume unchanged; rst_in pulse mid-run -> all outputs 0 at once.
